// File: rtl/stage_fifo_pkg.sv
// Shared defaults and sizing helper for the stage FIFO and its storage array.
package stage_fifo_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEPTH    = 4;
  localparam int DEFAULT_AF_LEVEL = 3;

  // Occupancy runs 0..depth inclusive, so one bit more than a pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stage_fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one combinational read port, no reset.
module stage_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stage_fifo.sv
// Single-clock valid/ready FIFO with occupancy count, almost-full and sticky overflow flags.
// Handshake: a word moves when valid && ready on the rising edge; ready/valid come from registered state only.
module stage_fifo
  import stage_fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEFAULT_AF_LEVEL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          almost_full,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stage_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("stage_fifo: AF_LEVEL must lie in 1..DEPTH");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign overflow    = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  stage_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_stage_fifo.sv
// Bench for stage_fifo: directed scenarios plus random traffic against a queue-based reference model.
module tb_stage_fifo;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int BRANCH   = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             overflow;

  // Same instance name in every branch; only the selected one is elaborated.
  if (BRANCH == 0) begin : g_a
    stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .almost_full(almost_full), .overflow(overflow));
  end else if (BRANCH == 1) begin : g_b
    stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .almost_full(almost_full), .overflow(overflow));
  end else begin : g_c
    stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .almost_full(almost_full), .overflow(overflow));
  end

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  bit               exp_ovf = 1'b0;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    int occ;
    occ = exp_q.size();
    check({ctx, ".count"},       32'(count),       32'(occ));
    check({ctx, ".out_valid"},   32'(out_valid),   32'(occ != 0));
    check({ctx, ".in_ready"},    32'(in_ready),    32'(occ != DEPTH));
    check({ctx, ".almost_full"}, 32'(almost_full), 32'(occ >= AF_LEVEL));
    check({ctx, ".overflow"},    32'(overflow),    32'(exp_ovf));
    if (occ != 0) begin
      check({ctx, ".out_data"}, 32'(out_data), 32'(exp_q[0]));
    end
  endtask

  // driver: one clock edge, model applied with the inputs seen at that edge
  task automatic step(input string ctx);
    bit do_push, do_pop;
    @(posedge clk);
    do_push = in_valid && (exp_q.size() < DEPTH);
    do_pop  = out_ready && (exp_q.size() > 0);
    if (in_valid && exp_q.size() == DEPTH) exp_ovf = 1'b1;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(in_data);
    #1;
    check_all(ctx);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string ctx);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_all(ctx);
    #1 rst = 1'b0;
  endtask

  initial begin
    // reset held across a few edges
    drive(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 rst = 1'b0;

    // single word round trip
    drive(1'b1, 8'hA5, 1'b0);
    step("push_a5");
    drive(1'b0, '0, 1'b1);
    step("pop_a5");
    drive(1'b0, '0, 1'b0);
    step("idle");

    // fill to full, then rejected fifth write
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      step("fill");
    end
    drive(1'b1, 8'hEE, 1'b0);
    step("overflow");
    drive(1'b0, '0, 1'b0);
    step("hold_full");

    // full with in_valid and out_ready: only the pop happens
    drive(1'b1, 8'h77, 1'b1);
    step("full_pop");
    drive(1'b0, '0, 1'b1);
    repeat (3) step("drain");

    // streaming at occupancy 2 over several pointer wraps
    drive(1'b1, 8'h00, 1'b0);
    step("pre0");
    drive(1'b1, 8'h01, 1'b0);
    step("pre1");
    for (int i = 2; i < 16; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1);
      step("stream");
    end
    drive(1'b0, '0, 1'b1);
    repeat (3) step("drain2");

    // asynchronous reset with three words stored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(8'h30 + i), 1'b0);
      step("pre_rst");
    end
    drive(1'b0, '0, 1'b0);
    async_reset("mid_rst");
    drive(1'b1, 8'h5A, 1'b0);
    step("push_5a");
    drive(1'b0, '0, 1'b1);
    step("pop_5a");

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 2) == 0));
      step("rand");
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
